tile_row_fetch_ctrl: RTL and testbench

//  Per-scanline prefetch sequencer for the tile renderer. On each line_start_i it walks the

---
 rtl/tile_row_fetch_ctrl_pkg.sv | 32 +++
 rtl/tile_row_fetch_ctrl_if.sv | 31 +++
 rtl/tile_row_fetch_ctrl_xlat.sv | 16 +
 rtl/tile_row_fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_tile_row_fetch_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/tile_row_fetch_ctrl_pkg.sv
// Shared constants, bus widths and FSM encoding for the scanline tile prefetcher.
package tile_row_fetch_ctrl_pkg;

  localparam int RAM_DATA_W     = 7;
  localparam int RAM_ADDR_W     = 9;
  localparam int ROM_ADDR_W     = 12;
  localparam int ROM_DATA_W     = 32;
  localparam int LB_ADDR_W      = 5;
  localparam int LINE_W         = 10;
  localparam int TILES_PER_ROW  = 20;
  localparam int TILE_PX        = 32;
  localparam int V_LINES        = 480;
  localparam int NUM_TILE_TYPES = 88;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // Glyph row address: each tile type owns TILE_PX consecutive ROM rows.
  // Unknown tile types fall back to ROM row 0.
  function automatic logic [ROM_ADDR_W-1:0] tile_rom_addr(
    input logic [RAM_DATA_W-1:0] tile_type,
    input logic [4:0]            mod32
  );
    if (tile_type >= RAM_DATA_W'(NUM_TILE_TYPES))
      return '0;
    return {tile_type, mod32};
  endfunction

endpackage

// File: rtl/tile_row_fetch_ctrl_if.sv
// Bus bundle between the prefetcher and its neighbours (timing gen, tile RAM, glyph ROM, line buffer).
interface tile_row_fetch_ctrl_if import tile_row_fetch_ctrl_pkg::*; ();

  logic                  line_start_i;
  logic [LINE_W-1:0]     next_line_i;
  logic                  ram_rd_o;
  logic [RAM_ADDR_W-1:0] ram_addr_o;
  logic [RAM_DATA_W-1:0] ram_data_i;
  logic                  rom_rd_o;
  logic [ROM_ADDR_W-1:0] rom_addr_o;
  logic [ROM_DATA_W-1:0] rom_data_i;
  logic                  lb_we_o;
  logic [LB_ADDR_W-1:0]  lb_addr_o;
  logic [ROM_DATA_W-1:0] lb_data_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  overrun_o;

  modport master (
    input  line_start_i, next_line_i, ram_data_i, rom_data_i,
    output ram_rd_o, ram_addr_o, rom_rd_o, rom_addr_o,
           lb_we_o, lb_addr_o, lb_data_o, busy_o, done_o, overrun_o
  );

  modport slave (
    output line_start_i, next_line_i, ram_data_i, rom_data_i,
    input  ram_rd_o, ram_addr_o, rom_rd_o, rom_addr_o,
           lb_we_o, lb_addr_o, lb_data_o, busy_o, done_o, overrun_o
  );

endinterface

// File: rtl/tile_row_fetch_ctrl_xlat.sv
// Tile-type to glyph-ROM row translator; forced to 0 while the block is in reset.
module tile_row_fetch_ctrl_xlat import tile_row_fetch_ctrl_pkg::*; (
  input  logic                  rst_i,
  input  logic [RAM_DATA_W-1:0] tile_type_i,
  input  logic [4:0]            mod32_i,
  output logic [ROM_ADDR_W-1:0] rom_addr_o
);

  // Purely combinational lookup so the ROM read issues in the same cycle the tile type arrives.
  always_comb begin
    rom_addr_o = '0;
    if (!rst_i)
      rom_addr_o = tile_rom_addr(tile_type_i, mod32_i);
  end

endmodule

// File: rtl/tile_row_fetch_ctrl.sv
// Scanline prefetcher: tile RAM read -> glyph ROM read -> line buffer write, one tile per cycle.
module tile_row_fetch_ctrl import tile_row_fetch_ctrl_pkg::*; #(
  parameter int TILES_PER_ROW = tile_row_fetch_ctrl_pkg::TILES_PER_ROW,
  parameter int V_LINES       = tile_row_fetch_ctrl_pkg::V_LINES
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  tile_row_fetch_ctrl_if.master bus
);

  localparam logic [4:0] LAST_COL = 5'(TILES_PER_ROW - 1);

  fetch_state_e          state;
  logic                  vld_p0, vld_p1, lb_we_p2;
  logic [4:0]            col_p0, col_p1;
  logic [LB_ADDR_W-1:0]  lb_addr_p2;
  logic [RAM_ADDR_W-1:0] ram_addr_p0;
  logic [RAM_ADDR_W-1:0] row_base_q;
  logic [4:0]            mod32_q;
  logic                  drain_cnt;
  logic                  busy_q, done_q, overrun_q;
  logic                  req_ok;
  logic [RAM_ADDR_W-1:0] req_base;
  logic [ROM_ADDR_W-1:0] xlat_addr;

  assign req_ok   = bus.line_start_i && (int'(bus.next_line_i) < V_LINES);
  assign req_base = RAM_ADDR_W'(bus.next_line_i[9:5]) * RAM_ADDR_W'(TILES_PER_ROW);

  // Sequencer: latch the request, walk the tile columns, then wait for the pipe to drain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      vld_p0      <= 1'b0;
      col_p0      <= '0;
      ram_addr_p0 <= '0;
      drain_cnt   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.line_start_i && busy_q)
        overrun_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (req_ok) begin
            state       <= ST_FETCH;
            busy_q      <= 1'b1;
            vld_p0      <= 1'b1;
            col_p0      <= '0;
            ram_addr_p0 <= req_base;
          end
        end
        ST_FETCH: begin
          if (col_p0 == LAST_COL) begin
            state       <= ST_DRAIN;
            vld_p0      <= 1'b0;
            ram_addr_p0 <= '0;
            drain_cnt   <= 1'b0;
          end else begin
            col_p0      <= col_p0 + 5'd1;
            ram_addr_p0 <= row_base_q + RAM_ADDR_W'(col_p0 + 5'd1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request fields and the column delay are pure data; valids qualify them downstream.
  always_ff @(posedge clk_i) begin
    if (state == ST_IDLE && req_ok) begin
      row_base_q <= req_base;
      mod32_q    <= bus.next_line_i[4:0];
    end
    col_p1 <= col_p0;
  end

  // ---- stage 1: tile type returns, ROM read issues ----
  // ---- stage 2: ROM row returns, line buffer write ----
  // Valid/slot delay pipe; cleared by reset so an interrupted line never writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1     <= 1'b0;
      lb_we_p2   <= 1'b0;
      lb_addr_p2 <= '0;
    end else begin
      vld_p1     <= vld_p0;
      lb_we_p2   <= vld_p1;
      lb_addr_p2 <= vld_p1 ? col_p1 : '0;
    end
  end

  tile_row_fetch_ctrl_xlat u_xlat (
    .rst_i       (~rst_ni),
    .tile_type_i (bus.ram_data_i),
    .mod32_i     (mod32_q),
    .rom_addr_o  (xlat_addr)
  );

  assign bus.ram_rd_o   = vld_p0;
  assign bus.ram_addr_o = ram_addr_p0;
  assign bus.rom_rd_o   = vld_p1;
  assign bus.rom_addr_o = vld_p1 ? xlat_addr : '0;
  assign bus.lb_we_o    = lb_we_p2;
  assign bus.lb_addr_o  = lb_addr_p2;
  assign bus.lb_data_o  = lb_we_p2 ? bus.rom_data_i : '0;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.overrun_o  = overrun_q;

endmodule

// File: tb/tb_tile_row_fetch_ctrl.sv
// Bench for the scanline tile prefetcher: memory models plus a per-cycle timing reference.
module tb_tile_row_fetch_ctrl;
  import tile_row_fetch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  tile_row_fetch_ctrl_if bus ();

  tile_row_fetch_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  logic [RAM_DATA_W-1:0] tile_ram  [0:511];
  logic [ROM_DATA_W-1:0] glyph_rom [0:4095];

  // Synchronous-read memories: data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (bus.ram_rd_o) bus.ram_data_i <= tile_ram[bus.ram_addr_o];
    if (bus.rom_rd_o) bus.rom_data_i <= glyph_rom[bus.rom_addr_o];
  end

  int n_pass = 0;
  int n_chk  = 0;
  bit exp_ovr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected ROM row from the glyph layout: 32 rows per known tile type, unknown -> row 0.
  function automatic int ref_rom_addr(input int t, input int m);
    if (t < 88) return t * 32 + m;
    return 0;
  endfunction

  // Issue a one-cycle request; returns at the negedge of cycle 1.
  task automatic start(input int line);
    bus.line_start_i = 1'b1;
    bus.next_line_i  = 10'(line);
    @(negedge clk);
    bus.line_start_i = 1'b0;
  endtask

  // Check cycles 1..23 of a line fetch; optionally raise a request in cycle stray_k.
  task automatic expect_line(input int line, input int stray_k, input int stray_line);
    int base, m, t;
    bit e_ram, e_rom, e_lb, e_busy;
    base = (line / 32) * TILES_PER_ROW;
    m    = line % 32;
    for (int k = 1; k <= 23; k++) begin
      e_ram  = (k >= 1 && k <= 20);
      e_rom  = (k >= 2 && k <= 21);
      e_lb   = (k >= 3 && k <= 22);
      e_busy = (k <= 22);
      chk($sformatf("ram_rd L%0d c%0d", line, k), bus.ram_rd_o, e_ram);
      if (e_ram) chk($sformatf("ram_addr L%0d c%0d", line, k), bus.ram_addr_o, base + k - 1);
      chk($sformatf("rom_rd L%0d c%0d", line, k), bus.rom_rd_o, e_rom);
      if (e_rom) begin
        t = int'(tile_ram[base + k - 2]);
        chk($sformatf("rom_addr L%0d c%0d", line, k), bus.rom_addr_o, ref_rom_addr(t, m));
      end
      chk($sformatf("lb_we L%0d c%0d", line, k), bus.lb_we_o, e_lb);
      if (e_lb) begin
        t = int'(tile_ram[base + k - 3]);
        chk($sformatf("lb_addr L%0d c%0d", line, k), bus.lb_addr_o, k - 3);
        chk($sformatf("lb_data L%0d c%0d", line, k), bus.lb_data_o, glyph_rom[ref_rom_addr(t, m)]);
      end
      chk($sformatf("busy L%0d c%0d", line, k), bus.busy_o, e_busy);
      chk($sformatf("done L%0d c%0d", line, k), bus.done_o, k == 23);
      chk($sformatf("overrun L%0d c%0d", line, k), bus.overrun_o, exp_ovr);
      if (k == stray_k) begin
        bus.line_start_i = 1'b1;
        bus.next_line_i  = 10'(stray_line);
      end
      @(negedge clk);
      bus.line_start_i = 1'b0;
      if (k == stray_k && e_busy) exp_ovr = 1'b1;
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      chk($sformatf("%s ram_rd %0d", tag, k), bus.ram_rd_o, 1'b0);
      chk($sformatf("%s lb_we %0d", tag, k), bus.lb_we_o, 1'b0);
      chk($sformatf("%s busy %0d", tag, k), bus.busy_o, 1'b0);
      chk($sformatf("%s done %0d", tag, k), bus.done_o, 1'b0);
      chk($sformatf("%s overrun %0d", tag, k), bus.overrun_o, exp_ovr);
      @(negedge clk);
    end
  endtask

  task automatic expect_all_zero(input string tag);
    chk({tag, " ram_rd"}, bus.ram_rd_o, 0);
    chk({tag, " ram_addr"}, bus.ram_addr_o, 0);
    chk({tag, " rom_rd"}, bus.rom_rd_o, 0);
    chk({tag, " rom_addr"}, bus.rom_addr_o, 0);
    chk({tag, " lb_we"}, bus.lb_we_o, 0);
    chk({tag, " lb_addr"}, bus.lb_addr_o, 0);
    chk({tag, " lb_data"}, bus.lb_data_o, 0);
    chk({tag, " busy"}, bus.busy_o, 0);
    chk({tag, " done"}, bus.done_o, 0);
    chk({tag, " overrun"}, bus.overrun_o, 0);
  endtask

  task automatic fill_row(input int line);
    int base;
    base = (line / 32) * TILES_PER_ROW;
    for (int c = 0; c < TILES_PER_ROW; c++) tile_ram[base + c] = 7'($urandom_range(0, 127));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int line;
    bus.line_start_i = 1'b0;
    bus.next_line_i  = '0;
    for (int i = 0; i < 512; i++) tile_ram[i] = 7'($urandom_range(0, 127));
    for (int i = 0; i < 4096; i++) glyph_rom[i] = $urandom;

    // Reset state
    repeat (3) @(negedge clk);
    expect_all_zero("reset");
    rst_ni = 1'b1;
    @(negedge clk);

    // Line 37: row 1, mod32 5, types 0..19
    for (int c = 0; c < TILES_PER_ROW; c++) tile_ram[20 + c] = 7'(c);
    start(37);
    expect_line(37, 0, 0);

    // Last visible line with the highest valid tile type
    for (int c = 0; c < TILES_PER_ROW; c++) tile_ram[280 + c] = 7'd87;
    start(479);
    expect_line(479, 0, 0);

    // First invisible line is ignored
    start(480);
    expect_quiet("line480", 25);

    // Unknown tile type in column 7 falls back to ROM row 0
    fill_row(200);
    tile_ram[120 + 7] = 7'd100;
    start(200);
    expect_line(200, 0, 0);

    // Request mid-fetch sets sticky overrun, current line intact, no extra done
    fill_row(100);
    start(100);
    expect_line(100, 10, 300);
    expect_quiet("after_overrun", 4);

    // Back-to-back: next request in the done cycle
    fill_row(64);
    fill_row(96);
    start(64);
    expect_line(64, 23, 96);
    expect_line(96, 0, 0);

    // Randomised visible lines
    for (int i = 0; i < 4; i++) begin
      line = int'($urandom_range(0, 479));
      fill_row(line);
      start(line);
      expect_line(line, 0, 0);
    end

    // Asynchronous reset in the middle of a fetch
    fill_row(150);
    start(150);
    repeat (7) @(negedge clk);
    rst_ni = 1'b0;
    exp_ovr = 1'b0;
    #1;
    expect_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    expect_quiet("post_reset", 30);

    // Normal operation resumes after reset
    fill_row(10);
    start(10);
    expect_line(10, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
